// File: rtl/addsub_pkg.sv
// rtl/addsub_pkg.sv - shared FSM encoding and sizing helpers for the digit-serial adder
package addsub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Cycles needed per operation
  function automatic int calc_n(input int width, input int digit);
    return width / digit;
  endfunction

  // Counter width; a single-cycle unit still keeps a 1-bit counter
  function automatic int calc_cnt_w(input int width, input int digit);
    int n;
    n = width / digit;
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rca_digit.sv
// rtl/rca_digit.sv - combinational DIGIT-bit ripple-carry full-adder slice
module rca_digit #(
  parameter int DIGIT = 2
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co,
  output logic             c_msb
);

  logic [DIGIT:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign co    = c[DIGIT];
  // Carry into the top bit of the slice; on the final digit this is the word MSB
  assign c_msb = c[DIGIT-1];

endmodule

// File: rtl/digit_serial_addsub.sv
// rtl/digit_serial_addsub.sv - multi-cycle add/subtract unit, DIGIT bits per clock
module digit_serial_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int N     = calc_n(WIDTH, DIGIT);
  localparam int CNT_W = calc_cnt_w(WIDTH, DIGIT);

  if ((WIDTH % DIGIT) != 0 || DIGIT < 1 || DIGIT > WIDTH) begin : g_bad_cfg
    $error("digit_serial_addsub: WIDTH must be a positive multiple of DIGIT");
  end

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   op_a, op_b, res;
  logic               carry;
  logic [CNT_W-1:0]   count;
  logic [DIGIT-1:0]   slice_s;
  logic               slice_co, slice_c_msb;
  logic               last;
  logic [WIDTH+DIGIT-1:0] res_cat;
  logic [WIDTH-1:0]   res_nxt;

  rca_digit #(.DIGIT(DIGIT)) u_slice (
    .a     (op_a[DIGIT-1:0]),
    .b     (op_b[DIGIT-1:0]),
    .ci    (carry),
    .s     (slice_s),
    .co    (slice_co),
    .c_msb (slice_c_msb)
  );

  // New digit enters at the MSB end so the LSB digit lands at bit 0 after N steps
  assign res_cat = {slice_s, res};
  assign res_nxt = res_cat[WIDTH+DIGIT-1:DIGIT];
  assign last    = (count == CNT_W'(N - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (in_valid)  state_nxt = ST_RUN;
      ST_RUN:  if (last)      state_nxt = ST_DONE;
      ST_DONE: if (out_ready) state_nxt = ST_IDLE;
      default:                state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == ST_IDLE);
    out_valid = (state == ST_DONE);
    busy      = (state == ST_RUN) || (state == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_a  <= '0;
      op_b  <= '0;
      res   <= '0;
      carry <= 1'b0;
      count <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            op_a  <= a;
            op_b  <= sub ? ~b : b;
            carry <= sub ? ~cin : cin;
            count <= '0;
          end
        end
        ST_RUN: begin
          op_a  <= op_a >> DIGIT;
          op_b  <= op_b >> DIGIT;
          res   <= res_nxt;
          carry <= slice_co;
          if (last) begin
            sum  <= res_nxt;
            cout <= slice_co;
            ovf  <= slice_c_msb ^ slice_co;
          end else begin
            count <= count + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_digit_serial_addsub.sv
// tb/tb_digit_serial_addsub.sv - self-checking bench for DIGIT = 2, 1 and 8 at WIDTH = 8
module tb_digit_serial_addsub;

  localparam int NDUT = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [7:0]       a, b;
  logic             cin, sub;
  logic             in_valid  [NDUT];
  logic             out_ready [NDUT];
  logic             in_ready  [NDUT];
  logic             out_valid [NDUT];
  logic [7:0]       sum_o     [NDUT];
  logic             cout_o    [NDUT];
  logic             ovf_o     [NDUT];
  logic             busy_o    [NDUT];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    digit_serial_addsub #(
      .WIDTH (8),
      .DIGIT ((g == 0) ? 2 : ((g == 1) ? 1 : 8))
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .sub       (sub),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .sum       (sum_o[g]),
      .cout      (cout_o[g]),
      .ovf       (ovf_o[g]),
      .busy      (busy_o[g])
    );
  end

  function automatic int digit_of(input int d);
    return (d == 0) ? 2 : ((d == 1) ? 1 : 8);
  endfunction

  task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s (DIGIT=%0d): observed %0h expected %0h", tag, digit_of(d), obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operation's meaning
  task automatic model(input logic [7:0] ta, input logic [7:0] tb, input logic tc, input logic ts,
                       output logic [7:0] es, output logic ec, output logic eo);
    int ua, ub, ur, sa, sb, sr;
    ua = int'(ta);
    ub = int'(tb);
    sa = int'($signed(ta));
    sb = int'($signed(tb));
    if (ts) begin
      ur = ua - ub - int'(tc);
      sr = sa - sb - int'(tc);
      ec = (ua >= ub + int'(tc));
    end else begin
      ur = ua + ub + int'(tc);
      sr = sa + sb + int'(tc);
      ec = (ur > 255);
    end
    es = 8'(ur);
    eo = (sr > 127) || (sr < -128);
  endtask

  task automatic run_op(input int d, input logic [7:0] ta, input logic [7:0] tb,
                        input logic tc, input logic ts, input int hold);
    int k, n;
    logic [7:0] es;
    logic ec, eo;
    n = 8 / digit_of(d);
    model(ta, tb, tc, ts, es, ec, eo);
    @(negedge clk);
    chk("in_ready_idle", d, 32'(in_ready[d]), 32'd1);
    a = ta; b = tb; cin = tc; sub = ts;
    in_valid[d] = 1'b1;
    @(negedge clk);
    in_valid[d] = 1'b0;
    a = ~ta; b = ~tb; cin = ~tc; sub = ~ts;
    chk("busy_run", d, {31'd0, busy_o[d]}, 32'd1);
    chk("in_ready_run", d, {31'd0, in_ready[d]}, 32'd0);
    k = 0;
    while (!out_valid[d] && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("latency", d, 32'(k), 32'(n));
    chk("sum", d, {24'd0, sum_o[d]}, {24'd0, es});
    chk("cout", d, {31'd0, cout_o[d]}, {31'd0, ec});
    chk("ovf", d, {31'd0, ovf_o[d]}, {31'd0, eo});
    for (int h = 0; h < hold; h++) begin
      in_valid[d] = 1'b1;
      @(negedge clk);
      in_valid[d] = 1'b0;
      chk("hold_valid", d, {31'd0, out_valid[d]}, 32'd1);
      chk("hold_sum", d, {24'd0, sum_o[d]}, {24'd0, es});
      chk("hold_cout_ovf", d, {30'd0, cout_o[d], ovf_o[d]}, {30'd0, ec, eo});
      chk("hold_in_ready", d, {31'd0, in_ready[d]}, 32'd0);
    end
    out_ready[d] = 1'b1;
    @(negedge clk);
    out_ready[d] = 1'b0;
    chk("post_hs_valid", d, {31'd0, out_valid[d]}, 32'd0);
    chk("post_hs_ready", d, {31'd0, in_ready[d]}, 32'd1);
    chk("post_hs_busy", d, {31'd0, busy_o[d]}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    for (int i = 0; i < NDUT; i++) begin
      in_valid[i]  = 1'b0;
      out_ready[i] = 1'b0;
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < NDUT; i++) begin
      chk("rst_in_ready", i, {31'd0, in_ready[i]}, 32'd1);
      chk("rst_out_valid", i, {31'd0, out_valid[i]}, 32'd0);
      chk("rst_busy", i, {31'd0, busy_o[i]}, 32'd0);
      chk("rst_sum", i, {24'd0, sum_o[i]}, 32'd0);
      chk("rst_cout_ovf", i, {30'd0, cout_o[i], ovf_o[i]}, 32'd0);
    end

    for (int d = 0; d < NDUT; d++) begin
      run_op(d, 8'h3C, 8'h0F, 1'b0, 1'b0, 0);
      run_op(d, 8'hFF, 8'h01, 1'b1, 1'b0, 0);
      run_op(d, 8'h7F, 8'h01, 1'b0, 1'b0, 0);
      run_op(d, 8'h80, 8'h80, 1'b0, 1'b0, 0);
      run_op(d, 8'h05, 8'h07, 1'b0, 1'b1, 0);
      run_op(d, 8'h09, 8'h03, 1'b1, 1'b1, 0);
      run_op(d, 8'h80, 8'h01, 1'b0, 1'b1, 0);
      for (int r = 0; r < 16; r++)
        run_op(d, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
    end

    // Backpressure with ignored in_valid pulses
    run_op(0, 8'h5A, 8'h33, 1'b1, 1'b0, 3);

    // Reset in the second RUN cycle drops the op
    @(negedge clk);
    a = 8'h11; b = 8'h22; cin = 1'b0; sub = 1'b0;
    in_valid[0] = 1'b1;
    @(negedge clk);
    in_valid[0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid_rst_busy", 0, {31'd0, busy_o[0]}, 32'd0);
    chk("mid_rst_in_ready", 0, {31'd0, in_ready[0]}, 32'd1);
    chk("mid_rst_out_valid", 0, {31'd0, out_valid[0]}, 32'd0);
    chk("mid_rst_sum", 0, {24'd0, sum_o[0]}, 32'd0);
    repeat (6) @(negedge clk);
    chk("mid_rst_no_result", 0, {31'd0, out_valid[0]}, 32'd0);
    run_op(0, 8'h10, 8'h20, 1'b0, 1'b0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
